mixed_prec_tag_buf: RTL and testbench
=====================================

# mixed_prec_tag_buf

Parametrised, tag-managed on-chip buffer that replaces the fixed per-buffer instances with one generic bank serving both 16-bit and 8-bit operands. AXI-side writes land in MEM_DATA_WIDTH lanes. Array-side reads return one ARRAY_N-element row, either native 16-bit or unpacked from packed 8-bit with sign-extension. NUM_TAGS slots, each with a FREE/FILL/FULL lifecycle, let loads and compute overlap.

## Interface
- NUM_TAGS, 2: number of tag slots; power of two, ≥2; TAG_W = $clog2(NUM_TAGS)
- ADDR_W, 10: physical row address width per tag
- ARRAY_N, 32: elements per array row
- DATA_WIDTH, 16: native element width; ROW_W = ARRAY_N*DATA_WIDTH
- MEM_DATA_WIDTH, 256: write word width; R = ROW_W/MEM_DATA_WIDTH, power of two ≥2; elaboration error otherwise
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- prec_mode  in  1  0 = 16-bit, 1 = 8-bit; latched into a tag on FREE→FILL
- mem_write_req  in  1  write strobe
- mem_write_addr  in  ADDR_W+$clog2(R)  word address within current fill tag
- mem_write_data  in  MEM_DATA_WIDTH  write word
- wr_tag_ready  out  1  fill tag is in FILL
- wr_tag_done  in  1  producer finished fill tag
- wr_drop  out  1  one-cycle pulse: write discarded
- rd_tag_valid  out  1  drain tag is FULL
- rd_prec  out  1  latched prec_mode of drain tag
- rd_tag_release  in  1  consumer finished drain tag
- buf_read_req  in  1  row read strobe
- buf_read_addr  in  ADDR_W+1  logical row address
- buf_read_data  out  ROW_W  unpacked row
- buf_read_valid  out  1  buf_read_data valid
- fill_tag, drain_tag  out  TAG_W  current pointers

## Operation
- Per-tag state: FREE→FILL (automatic, when tag == fill_ptr and FREE) → FULL (wr_tag_done) → FREE (rd_tag_release).
- Moving to FILL latches prec_mode into tag_prec[tag].
- wr_tag_done while wr_tag_ready=0 is ignored. Otherwise the tag goes FULL and fill_ptr increments mod NUM_TAGS.
- rd_tag_release while rd_tag_valid=0 is ignored. Otherwise the tag goes FREE and drain_ptr increments mod NUM_TAGS.
- Write addressing is identical in both modes:
  - Physical row = mem_write_addr >> $clog2(R).
  - Lane = low $clog2(R) bits. Only that lane of the row is written.
  - Written only when wr_tag_ready=1; otherwise wr_drop pulses the next cycle and RAM is unchanged.
- Read in 16-bit mode (rd_prec=0): physical row = buf_read_addr[ADDR_W-1:0]; bit ADDR_W ignored; data passed through.
- Read in 8-bit mode (rd_prec=1):
  - Physical row = buf_read_addr[ADDR_W:1]; half = buf_read_addr[0], 0 = low ROW_W/2 bits.
  - Byte k of the half is sign-extended to DATA_WIDTH and drives element k.
- buf_read_req with rd_tag_valid=0 is ignored: no RAM access, no valid.
- Simultaneous wr_tag_done and rd_tag_release on different tags are both applied in the same cycle.
- A tag freed by release cannot re-enter FILL before the following cycle.

## Timing
- Reset values: fill_ptr=drain_ptr=0; all tags FREE; every output 0, including buf_read_data and wr_drop.
- First cycle after reset release: tag 0 goes FILL; wr_tag_ready=1 from the second cycle.
- Write: RAM updated at the edge ending the request cycle. A same-cycle read of the same row returns old data.
- Read latency is 2:
  - Request in cycle N; synchronous RAM read at edge N→N+1.
  - Unpack register at edge N+1→N+2.
  - buf_read_valid=1 in cycle N+2 only. Fully pipelined, one read per cycle.
- Release in cycle N does not corrupt reads issued in cycles ≤N; they complete with pre-release data.
- rd_tag_valid, wr_tag_ready, rd_prec and the pointers update one cycle after the causing event.
- Reset mid-operation: in-flight reads are dropped (valid forced 0), tags go FREE, RAM contents are undefined/unspecified.

## Structure
- Package mixed_prec_buf_pkg holds:
  - Tag state enum {TAG_FREE, TAG_FILL, TAG_FULL}.
  - PREC_16=0, PREC_8=1.
  - Function sext8 (byte → DATA_WIDTH).
- Sub-module tag_buf_ram: simple dual-port RAM, depth NUM_TAGS·2^ADDR_W, R lane write enables, registered read. Addresses are {tag, row}.
- Top contains the tag FSM array, pointers, address decode and unpack pipeline.

## Test plan
Bench parameters: ARRAY_N=4, DATA_WIDTH=16, MEM_DATA_WIDTH=32, ADDR_W=3, NUM_TAGS=2.
- 16-bit round trip: prec_mode=0; write addr0=0x0002_0001, addr1=0x0004_0003; wr_tag_done; read addr 0 → buf_read_valid 2 cycles later, data 0x0004_0003_0002_0001, rd_prec=0.
- 8-bit unpack: prec_mode=1; write addr0=0x807F_01FF, addr1=0x0000_0002; done.
  - Read logical 0 → 0xFF80_007F_0001_FFFF.
  - Read logical 1 → 0x0000_0000_0000_0002.
- Ping-pong: fill tag0, done; fill tag1 (prec 1) while reading tag0 (prec 0); release tag0.
  - Each tag returns its own data and mode.
  - Tag0 re-enters FILL the cycle after release.
- Overflow: fill both tags and done, no release → wr_tag_ready=0; a write → wr_drop pulse, RAM unchanged; a further done → ignored.
- Empty read: rd_tag_valid=0, buf_read_req=1 → buf_read_valid stays 0.
- Concurrency and reset: done and release in the same cycle → pointers both advance; reset asserted with 2 reads in flight → no valid, all tags FREE, pointers 0.

Source files
------------

// File: rtl/mixed_prec_buf_pkg.sv
// Shared types and helpers for the mixed-precision tag buffer.
package mixed_prec_buf_pkg;

    // Lifecycle of one tag slot.
    typedef enum logic [1:0] {
        TAG_FREE = 2'd0,
        TAG_FILL = 2'd1,
        TAG_FULL = 2'd2
    } tag_state_e;

    localparam logic PREC_16 = 1'b0;
    localparam logic PREC_8  = 1'b1;

    // Widest element the helper can produce; callers truncate to their DATA_WIDTH.
    localparam int SEXT_MAX_W = 64;

    function automatic logic [SEXT_MAX_W-1:0] sext8(input logic [7:0] b);
        return {{(SEXT_MAX_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/tag_buf_ram.sv
// Simple dual-port RAM: per-lane write enables, one registered full-row read port.
// Read-before-write: a same-cycle read of the row being written returns old data.
module tag_buf_ram #(
    parameter int DEPTH_W = 4,
    parameter int ROW_W   = 64,
    parameter int LANE_W  = 32,
    parameter int R       = 2
) (
    input  logic                 clk_i,
    input  logic [R-1:0]         we_i,
    input  logic [DEPTH_W-1:0]   waddr_i,
    input  logic [LANE_W-1:0]    wdata_i,
    input  logic                 re_i,
    input  logic [DEPTH_W-1:0]   raddr_i,
    output logic [ROW_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [ROW_W-1:0] mem_q [DEPTH];
    logic [ROW_W-1:0] rdata_q;

    // Lane writes and registered row read share one edge; no reset on storage.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < R; l++) begin
            if (we_i[l]) begin
                mem_q[waddr_i][l*LANE_W +: LANE_W] <= wdata_i;
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mixed_prec_tag_buf.sv
// Tag-managed row buffer: lane-wide writes into the fill tag, full-row reads
// from the drain tag, optional 8-bit to DATA_WIDTH sign-extending unpack.
//
// state    | meaning
// TAG_FREE | slot empty; becomes FILL when it is the fill pointer
// TAG_FILL | producer writing; prec_mode latched on entry
// TAG_FULL | data ready for the consumer until released
module mixed_prec_tag_buf
    import mixed_prec_buf_pkg::*;
#(
    parameter int NUM_TAGS       = 2,
    parameter int ADDR_W         = 10,
    parameter int ARRAY_N        = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_DATA_WIDTH = 256
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  prec_mode_i,
    input  logic                                  mem_write_req_i,
    input  logic [ADDR_W+$clog2(ARRAY_N*DATA_WIDTH/MEM_DATA_WIDTH)-1:0] mem_write_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0]             mem_write_data_i,
    output logic                                  wr_tag_ready_o,
    input  logic                                  wr_tag_done_i,
    output logic                                  wr_drop_o,
    output logic                                  rd_tag_valid_o,
    output logic                                  rd_prec_o,
    input  logic                                  rd_tag_release_i,
    input  logic                                  buf_read_req_i,
    input  logic [ADDR_W:0]                       buf_read_addr_i,
    output logic [ARRAY_N*DATA_WIDTH-1:0]         buf_read_data_o,
    output logic                                  buf_read_valid_o,
    output logic [$clog2(NUM_TAGS)-1:0]           fill_tag_o,
    output logic [$clog2(NUM_TAGS)-1:0]           drain_tag_o
);

    localparam int TAG_W  = $clog2(NUM_TAGS);
    localparam int ROW_W  = ARRAY_N * DATA_WIDTH;
    localparam int R      = ROW_W / MEM_DATA_WIDTH;
    localparam int LANE_W = $clog2(R);
    localparam int WA_W   = ADDR_W + LANE_W;

    if ((R < 2) || ((R & (R - 1)) != 0) || (R * MEM_DATA_WIDTH != ROW_W)) begin : g_bad_r
        $error("ROW_W/MEM_DATA_WIDTH must be a power of two >= 2");
    end
    if ((NUM_TAGS < 2) || ((NUM_TAGS & (NUM_TAGS - 1)) != 0)) begin : g_bad_tags
        $error("NUM_TAGS must be a power of two >= 2");
    end
    if ((DATA_WIDTH < 16) || (DATA_WIDTH > SEXT_MAX_W)) begin : g_bad_dw
        $error("DATA_WIDTH must lie in 16..64 for the 8-bit unpack");
    end

    tag_state_e        tag_state_q [NUM_TAGS];
    tag_state_e        tag_state_d [NUM_TAGS];
    logic              tag_prec_q  [NUM_TAGS];
    logic              tag_prec_d  [NUM_TAGS];
    logic [TAG_W-1:0]  fill_ptr_q, fill_ptr_d;
    logic [TAG_W-1:0]  drain_ptr_q, drain_ptr_d;

    logic              wr_ready, rd_valid, rd_prec;
    logic              wr_accept, rd_accept;
    logic [R-1:0]      ram_we;
    logic [ADDR_W-1:0] wr_row, rd_row;
    logic [LANE_W-1:0] wr_lane;
    logic [ROW_W-1:0]  ram_rdata;

    logic              rd_v1_q, rd_half_q, rd_prec1_q;
    logic              rd_valid_q, wr_drop_q;
    logic [ROW_W-1:0]  rd_data_q, rd_data_d;
    logic [ROW_W/2-1:0] half_bits;
    logic [ROW_W-1:0]  unpacked;

    assign wr_ready = (tag_state_q[fill_ptr_q] == TAG_FILL);
    assign rd_valid = (tag_state_q[drain_ptr_q] == TAG_FULL);
    assign rd_prec  = tag_prec_q[drain_ptr_q];

    assign wr_accept = mem_write_req_i & wr_ready;
    assign rd_accept = buf_read_req_i & rd_valid;

    assign wr_row  = mem_write_addr_i[WA_W-1:LANE_W];
    assign wr_lane = mem_write_addr_i[LANE_W-1:0];
    assign rd_row  = (rd_prec == PREC_8) ? buf_read_addr_i[ADDR_W:1]
                                         : buf_read_addr_i[ADDR_W-1:0];

    // One-hot lane enable for the accepted write.
    always_comb begin
        ram_we = '0;
        for (int l = 0; l < R; l++) begin
            ram_we[l] = wr_accept && (wr_lane == LANE_W'(l));
        end
    end

    // Per-tag lifecycle; only the fill tag can be in FILL, only the drain tag is released.
    always_comb begin
        for (int t = 0; t < NUM_TAGS; t++) begin
            tag_state_d[t] = tag_state_q[t];
            tag_prec_d[t]  = tag_prec_q[t];
            case (tag_state_q[t])
                TAG_FREE: begin
                    if (TAG_W'(t) == fill_ptr_q) begin
                        tag_state_d[t] = TAG_FILL;
                        tag_prec_d[t]  = prec_mode_i;
                    end
                end
                TAG_FILL: begin
                    if (wr_tag_done_i && (TAG_W'(t) == fill_ptr_q)) begin
                        tag_state_d[t] = TAG_FULL;
                    end
                end
                TAG_FULL: begin
                    if (rd_tag_release_i && (TAG_W'(t) == drain_ptr_q)) begin
                        tag_state_d[t] = TAG_FREE;
                    end
                end
                default: tag_state_d[t] = TAG_FREE;
            endcase
        end
        fill_ptr_d  = (wr_tag_done_i && wr_ready)    ? fill_ptr_q + TAG_W'(1)  : fill_ptr_q;
        drain_ptr_d = (rd_tag_release_i && rd_valid) ? drain_ptr_q + TAG_W'(1) : drain_ptr_q;
    end

    // Tag state and pointer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                tag_state_q[t] <= TAG_FREE;
                tag_prec_q[t]  <= PREC_16;
            end
            fill_ptr_q  <= '0;
            drain_ptr_q <= '0;
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                tag_state_q[t] <= tag_state_d[t];
                tag_prec_q[t]  <= tag_prec_d[t];
            end
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
        end
    end

    tag_buf_ram #(
        .DEPTH_W (TAG_W + ADDR_W),
        .ROW_W   (ROW_W),
        .LANE_W  (MEM_DATA_WIDTH),
        .R       (R)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i ({fill_ptr_q, wr_row}),
        .wdata_i (mem_write_data_i),
        .re_i    (rd_accept),
        .raddr_i ({drain_ptr_q, rd_row}),
        .rdata_o (ram_rdata)
    );

    // Select the addressed half and sign-extend each byte into one element.
    always_comb begin
        unpacked  = '0;
        half_bits = rd_half_q ? ram_rdata[ROW_W-1:ROW_W/2] : ram_rdata[ROW_W/2-1:0];
        for (int k = 0; k < ARRAY_N; k++) begin
            unpacked[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sext8(half_bits[k*8 +: 8]));
        end
        rd_data_d = (rd_prec1_q == PREC_8) ? unpacked : ram_rdata;
    end

    // Read pipeline (mode and half travel with the request) and the drop pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v1_q    <= 1'b0;
            rd_half_q  <= 1'b0;
            rd_prec1_q <= PREC_16;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_v1_q <= rd_accept;
            if (rd_accept) begin
                rd_half_q  <= buf_read_addr_i[0];
                rd_prec1_q <= rd_prec;
            end
            rd_valid_q <= rd_v1_q;
            if (rd_v1_q) begin
                rd_data_q <= rd_data_d;
            end
            wr_drop_q <= mem_write_req_i & ~wr_ready;
        end
    end

    assign wr_tag_ready_o   = wr_ready;
    assign rd_tag_valid_o   = rd_valid;
    assign rd_prec_o        = rd_prec;
    assign wr_drop_o        = wr_drop_q;
    assign buf_read_valid_o = rd_valid_q;
    assign buf_read_data_o  = rd_data_q;
    assign fill_tag_o       = fill_ptr_q;
    assign drain_tag_o      = drain_ptr_q;

endmodule

// File: tb/tb_mixed_prec_tag_buf.sv
// Directed bench for mixed_prec_tag_buf; inputs driven and outputs sampled on negedge.
module tb_mixed_prec_tag_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        prec_mode;
    logic        mem_write_req;
    logic [3:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        wr_tag_ready;
    logic        wr_tag_done;
    logic        wr_drop;
    logic        rd_tag_valid;
    logic        rd_prec;
    logic        rd_tag_release;
    logic        buf_read_req;
    logic [3:0]  buf_read_addr;
    logic [63:0] buf_read_data;
    logic        buf_read_valid;
    logic [0:0]  fill_tag;
    logic [0:0]  drain_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mixed_prec_tag_buf #(
        .NUM_TAGS       (2),
        .ADDR_W         (3),
        .ARRAY_N        (4),
        .DATA_WIDTH     (16),
        .MEM_DATA_WIDTH (32)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .prec_mode_i      (prec_mode),
        .mem_write_req_i  (mem_write_req),
        .mem_write_addr_i (mem_write_addr),
        .mem_write_data_i (mem_write_data),
        .wr_tag_ready_o   (wr_tag_ready),
        .wr_tag_done_i    (wr_tag_done),
        .wr_drop_o        (wr_drop),
        .rd_tag_valid_o   (rd_tag_valid),
        .rd_prec_o        (rd_prec),
        .rd_tag_release_i (rd_tag_release),
        .buf_read_req_i   (buf_read_req),
        .buf_read_addr_i  (buf_read_addr),
        .buf_read_data_o  (buf_read_data),
        .buf_read_valid_o (buf_read_valid),
        .fill_tag_o       (fill_tag),
        .drain_tag_o      (drain_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        mem_write_req  = 1'b1;
        mem_write_addr = a;
        mem_write_data = d;
        cyc();
        mem_write_req  = 1'b0;
    endtask

    task automatic tag_done();
        wr_tag_done = 1'b1;
        cyc();
        wr_tag_done = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [63:0] exp);
        buf_read_req  = 1'b1;
        buf_read_addr = a;
        cyc();
        buf_read_req  = 1'b0;
        check({tag, "_v1"}, 64'(buf_read_valid), 64'd0);
        cyc();
        check({tag, "_v2"}, 64'(buf_read_valid), 64'd1);
        check({tag, "_data"}, buf_read_data, exp);
    endtask

    initial begin
        reset = 1'b1; prec_mode = 1'b0;
        mem_write_req = 1'b0; mem_write_addr = '0; mem_write_data = '0;
        wr_tag_done = 1'b0; rd_tag_release = 1'b0;
        buf_read_req = 1'b0; buf_read_addr = '0;
        repeat (3) cyc();

        check("rst_ready", 64'(wr_tag_ready), 64'd0);
        check("rst_rdvalid", 64'(rd_tag_valid), 64'd0);
        check("rst_bvalid", 64'(buf_read_valid), 64'd0);
        check("rst_bdata", buf_read_data, 64'd0);
        check("rst_drop", 64'(wr_drop), 64'd0);
        check("rst_ptrs", {62'd0, fill_tag, drain_tag}, 64'd0);
        check("rst_prec", 64'(rd_prec), 64'd0);

        // First cycle after release: tag0 still FREE, FILL from the next cycle.
        reset = 1'b0;
        #1 check("ready_cyc1", 64'(wr_tag_ready), 64'd0);
        cyc();
        check("ready_cyc2", 64'(wr_tag_ready), 64'd1);

        // 16-bit fill of tag0.
        wr(4'd0, 32'h0002_0001);
        wr(4'd1, 32'h0004_0003);
        tag_done();
        check("t0done_fill", 64'(fill_tag), 64'd1);
        check("t0done_drain", 64'(drain_tag), 64'd0);
        check("t0done_rdvalid", 64'(rd_tag_valid), 64'd1);
        check("t0done_rdprec", 64'(rd_prec), 64'd0);
        check("t0done_ready", 64'(wr_tag_ready), 64'd0);
        prec_mode = 1'b1;
        cyc();
        check("t1_ready", 64'(wr_tag_ready), 64'd1);

        // Ping-pong: fill tag1 in 8-bit mode while reading tag0.
        rd("rd16_a", 4'd0, 64'h0004_0003_0002_0001);
        wr(4'd0, 32'h807F_01FF);
        rd("rd16_b", 4'd0, 64'h0004_0003_0002_0001);
        wr(4'd1, 32'h0000_0002);
        tag_done();
        check("both_full_fill", 64'(fill_tag), 64'd0);
        check("both_full_ready", 64'(wr_tag_ready), 64'd0);
        check("both_full_rdvalid", 64'(rd_tag_valid), 64'd1);

        // Overflow: dropped write, ignored done.
        wr(4'd0, 32'hDEAD_BEEF);
        check("drop_pulse", 64'(wr_drop), 64'd1);
        cyc();
        check("drop_end", 64'(wr_drop), 64'd0);
        tag_done();
        check("done_ignored_fill", 64'(fill_tag), 64'd0);
        check("done_ignored_drain", 64'(drain_tag), 64'd0);

        // Release tag0 with a read issued in the same cycle.
        rd_tag_release = 1'b1;
        buf_read_req   = 1'b1;
        buf_read_addr  = 4'd0;
        prec_mode      = 1'b0;
        cyc();
        rd_tag_release = 1'b0;
        buf_read_req   = 1'b0;
        check("rel_drain", 64'(drain_tag), 64'd1);
        check("rel_rdvalid", 64'(rd_tag_valid), 64'd1);
        check("rel_rdprec", 64'(rd_prec), 64'd1);
        check("rel_ready_free", 64'(wr_tag_ready), 64'd0);
        check("rel_rd_v1", 64'(buf_read_valid), 64'd0);
        cyc();
        check("rel_ready_fill", 64'(wr_tag_ready), 64'd1);
        check("rel_rd_v2", 64'(buf_read_valid), 64'd1);
        check("rel_rd_data", buf_read_data, 64'h0004_0003_0002_0001);

        // Back-to-back 8-bit reads of tag1.
        buf_read_req  = 1'b1;
        buf_read_addr = 4'd0;
        cyc();
        buf_read_addr = 4'd1;
        cyc();
        buf_read_req  = 1'b0;
        check("rd8_lo_v", 64'(buf_read_valid), 64'd1);
        check("rd8_lo_data", buf_read_data, 64'hFF80_007F_0001_FFFF);
        cyc();
        check("rd8_hi_v", 64'(buf_read_valid), 64'd1);
        check("rd8_hi_data", buf_read_data, 64'h0000_0000_0000_0002);
        cyc();
        check("rd8_idle_v", 64'(buf_read_valid), 64'd0);

        // Refill tag0 (16-bit), then done and release in the same cycle.
        wr(4'd2, 32'h1111_2222);
        wr(4'd3, 32'h3333_4444);
        wr_tag_done    = 1'b1;
        rd_tag_release = 1'b1;
        cyc();
        wr_tag_done    = 1'b0;
        rd_tag_release = 1'b0;
        check("conc_fill", 64'(fill_tag), 64'd1);
        check("conc_drain", 64'(drain_tag), 64'd0);
        check("conc_rdvalid", 64'(rd_tag_valid), 64'd1);
        check("conc_rdprec", 64'(rd_prec), 64'd0);
        rd("rd16_row1", 4'd1, 64'h3333_4444_1111_2222);
        rd("rd16_msb_ignored", 4'd9, 64'h3333_4444_1111_2222);

        // Release tag0; tag1 is filling, so nothing to drain.
        rd_tag_release = 1'b1;
        cyc();
        rd_tag_release = 1'b0;
        check("empty_rdvalid", 64'(rd_tag_valid), 64'd0);
        buf_read_req  = 1'b1;
        buf_read_addr = 4'd0;
        cyc();
        buf_read_req  = 1'b0;
        check("empty_v1", 64'(buf_read_valid), 64'd0);
        cyc();
        check("empty_v2", 64'(buf_read_valid), 64'd0);

        // Reset with two reads in flight.
        tag_done();
        check("pre_rst_rdvalid", 64'(rd_tag_valid), 64'd1);
        buf_read_req  = 1'b1;
        buf_read_addr = 4'd0;
        cyc();
        buf_read_addr = 4'd1;
        reset = 1'b1;
        cyc();
        buf_read_req = 1'b0;
        check("rst_flight_v1", 64'(buf_read_valid), 64'd0);
        cyc();
        check("rst_flight_v2", 64'(buf_read_valid), 64'd0);
        check("rst_flight_rdvalid", 64'(rd_tag_valid), 64'd0);
        check("rst_flight_ready", 64'(wr_tag_ready), 64'd0);
        check("rst_flight_ptrs", {62'd0, fill_tag, drain_tag}, 64'd0);
        check("rst_flight_data", buf_read_data, 64'd0);
        reset = 1'b0;
        cyc();
        cyc();
        check("post_rst_ready", 64'(wr_tag_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
